// File: rtl/lc3_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_bus_pkg
// Description : Shared LC-3 bus types, widths and source names.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_bus_pkg;

    localparam int LC3_WORD_W    = 16;
    localparam int LC3_BUS_SRC_N = 4;

    typedef logic [15:0] lc3_word_t;

    // Q_Sel values of the standard four-source bus
    typedef enum logic [1:0] {
        SRC_PC,
        SRC_ALU,
        SRC_MDR,
        SRC_MARMUX
    } lc3_bus_src_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Scans from ptr upward with
//               wrap-around and returns the first requester one-hot and binary.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int  N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        logic             w_found;
        int               w_pos;
        logic [SEL_W-1:0] w_sel;
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            // ptr is always below N, so a single subtraction wraps the scan
            w_pos = int'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = SEL_W'(w_pos);
            if (enable && !w_found && req[w_sel]) begin
                grant[w_sel] = 1'b1;
                idx          = w_sel;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_bus_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_bus_mux
// Description : Registered N-to-1 LC-3 bus mux with round-robin arbitration
//               and a one-entry valid/ready output register.
//               Optional macro RR_BUS_MUX_LOCK_EN adds a lock input that keeps
//               the granted source at top priority for bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_bus_mux
    import lc3_bus_pkg::*;
#(
    parameter int  WIDTH = LC3_WORD_W,
    parameter int  N     = LC3_BUS_SRC_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset,
`ifdef RR_BUS_MUX_LOCK_EN
    input  logic               lock,
`endif
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] data_in,
    output logic [N-1:0]       grant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Q_Out,
    output logic [SEL_W-1:0]   Q_Sel
);

    localparam logic [0:0]       c_st_empty = 1'b0;
    localparam logic [0:0]       c_st_full  = 1'b1;
    localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(N - 1);

    logic [0:0]       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_q_sel;
    logic [WIDTH-1:0] r_q_out;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_ptr_next;
    logic             w_accept;
    logic             w_lock;
    logic [WIDTH-1:0] w_src [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_src[gi] = data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef RR_BUS_MUX_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Reset masks accept so no grant is ever shown during a reset cycle
    assign w_accept = !Reset && (|req) && ((r_state == c_st_empty) || out_ready);

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .req    (req),
        .ptr    (r_ptr),
        .enable (w_accept),
        .grant  (grant),
        .idx    (w_idx)
    );

    always_comb begin
        if (w_lock) begin
            w_ptr_next = w_idx;
        end else if (w_idx == c_last_idx) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_st_empty;
            r_q_out <= '0;
            r_q_sel <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_state <= c_st_full;
            r_q_out <= w_src[w_idx];
            r_q_sel <= w_idx;
            r_ptr   <= w_ptr_next;
        end else if ((r_state == c_st_full) && out_ready) begin
            r_state <= c_st_empty;
        end
    end

    assign out_valid = (r_state == c_st_full);
    assign Q_Out     = r_q_out;
    assign Q_Sel     = r_q_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_bus_mux
// Description : Self-checking bench: directed vector table, N=3 wrap sequence,
//               randomized run against a reference model, optional lock burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_bus_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lock = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] data_in = '0;
    logic        out_ready = 1'b1;
    logic [3:0]  grant;
    logic        out_valid;
    logic [15:0] q_out;
    logic [1:0]  q_sel;

    logic [2:0]  req3 = '0;
    logic [47:0] data3 = 48'h3333_2222_1111;
    logic [2:0]  grant3;
    logic        valid3;
    logic [15:0] q3;
    logic [1:0]  sel3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_bus_mux #(.WIDTH(16), .N(4)) u_dut (
        .Clk       (clk),
        .Reset     (rst),
`ifdef RR_BUS_MUX_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q_Out     (q_out),
        .Q_Sel     (q_sel)
    );

    rr_bus_mux #(.WIDTH(16), .N(3)) u_dut3 (
        .Clk       (clk),
        .Reset     (rst),
`ifdef RR_BUS_MUX_LOCK_EN
        .lock      (1'b0),
`endif
        .req       (req3),
        .data_in   (data3),
        .grant     (grant3),
        .out_valid (valid3),
        .out_ready (1'b1),
        .Q_Out     (q3),
        .Q_Sel     (sel3)
    );

    typedef struct {
        logic        rs;
        logic [3:0]  r;
        logic        rdy;
        logic [63:0] d;
        logic [3:0]  eg;
        logic        ev;
        logic [15:0] eq;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] D0 = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [63:0] D1 = 64'hDDDD_CCCC_1234_AAAA;
    localparam logic [63:0] D2 = 64'hDDDD_CCCC_BEEF_AAAA;

    // reference model state
    bit          m_valid;
    logic [15:0] m_q;
    int          m_sel;
    int          m_ptr;

    function automatic void add(logic rs, logic [3:0] r, logic rdy, logic [63:0] d,
                                logic [3:0] eg, logic ev, logic [15:0] eq, logic [1:0] es);
        vec_t v;
        v.rs = rs; v.r = r; v.rdy = rdy; v.d = d;
        v.eg = eg; v.ev = ev; v.eq = eq; v.es = es;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, input logic [3:0] r, input logic rdy,
                         input logic [63:0] d, input logic lk);
        @(negedge clk);
        rst = rs; req = r; out_ready = rdy; data_in = d; lock = lk;
        #1;
    endtask

    function automatic logic [3:0] ref_grant(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    initial begin
        // rs  req     rdy data  | grant   v  Q_Out     Q_Sel
        add(1, 4'b1111, 1, D0,    4'b0000, 0, 16'h0000, 0);
        add(1, 4'b1111, 1, D0,    4'b0000, 0, 16'h0000, 0);
        add(0, 4'b0000, 1, D0,    4'b0000, 0, 16'h0000, 0);
        add(0, 4'b0000, 1, D0,    4'b0000, 0, 16'h0000, 0);
        add(0, 4'b0000, 1, D0,    4'b0000, 0, 16'h0000, 0);
        add(0, 4'b1111, 1, D0,    4'b0001, 0, 16'h0000, 0);
        add(0, 4'b1111, 1, D0,    4'b0010, 1, 16'hAAAA, 0);
        add(0, 4'b1111, 1, D0,    4'b0100, 1, 16'hBBBB, 1);
        add(0, 4'b1111, 1, D0,    4'b1000, 1, 16'hCCCC, 2);
        add(0, 4'b1111, 1, D0,    4'b0001, 1, 16'hDDDD, 3);
        add(0, 4'b0000, 1, D0,    4'b0000, 1, 16'hAAAA, 0);
        add(0, 4'b0000, 1, D0,    4'b0000, 0, 16'hAAAA, 0);
        add(0, 4'b0010, 0, D1,    4'b0010, 0, 16'hAAAA, 0);
        add(0, 4'b0100, 0, D0,    4'b0000, 1, 16'h1234, 1);
        add(0, 4'b0100, 0, D0,    4'b0000, 1, 16'h1234, 1);
        add(0, 4'b0100, 0, D0,    4'b0000, 1, 16'h1234, 1);
        add(0, 4'b0100, 0, D0,    4'b0000, 1, 16'h1234, 1);
        add(0, 4'b0100, 1, D0,    4'b0100, 1, 16'h1234, 1);
        add(0, 4'b0000, 0, D0,    4'b0000, 1, 16'hCCCC, 2);
        add(0, 4'b0010, 1, D2,    4'b0010, 1, 16'hCCCC, 2);
        add(1, 4'b0001, 1, D0,    4'b0000, 1, 16'hBEEF, 1);
        add(0, 4'b0101, 1, D0,    4'b0001, 0, 16'h0000, 0);
        add(0, 4'b0000, 1, D0,    4'b0000, 1, 16'hAAAA, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rs, tbl[i].r, tbl[i].rdy, tbl[i].d, 1'b0);
            chk($sformatf("vec%0d grant", i), 64'(grant), 64'(tbl[i].eg));
            chk($sformatf("vec%0d valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d q_out", i), 64'(q_out), 64'(tbl[i].eq));
            chk($sformatf("vec%0d q_sel", i), 64'(q_sel), 64'(tbl[i].es));
        end

        // N=3: grant source 1 (ptr->2), then req 011 must wrap to source 0
        drive(0, 4'b0000, 1, D0, 1'b0);
        req3 = 3'b010; #1;
        chk("n3 grant src1", 64'(grant3), 64'(3'b010));
        drive(0, 4'b0000, 1, D0, 1'b0);
        req3 = 3'b011; #1;
        chk("n3 wrap grant", 64'(grant3), 64'(3'b001));
        chk("n3 q_out", 64'(q3), 64'(16'h2222));
        chk("n3 q_sel", 64'(sel3), 64'(2'd1));
        drive(0, 4'b0000, 1, D0, 1'b0);
        req3 = 3'b011; #1;
        chk("n3 ptr1 grant", 64'(grant3), 64'(3'b010));
        chk("n3 q_out wrap", 64'(q3), 64'(16'h1111));
        chk("n3 q_sel wrap", 64'(sel3), 64'(2'd0));
        drive(0, 4'b0000, 1, D0, 1'b0);
        req3 = 3'b000; #1;
        chk("n3 idle grant", 64'(grant3), 64'(3'b000));
        chk("n3 last valid", 64'(valid3), 64'(1'b1));
        chk("n3 last sel", 64'(sel3), 64'(2'd1));

        // randomized run against the reference model
        drive(1, 4'b0000, 1, D0, 1'b0);
        m_valid = 0; m_q = '0; m_sel = 0; m_ptr = 0;
        for (int n = 0; n < 400; n++) begin
            logic        rs, rdy, lk, acc;
            logic [3:0]  r, eg;
            logic [63:0] d;
            int          g;
            rs  = ($urandom_range(0, 39) == 0);
            r   = 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            d   = {$urandom, $urandom};
`ifdef RR_BUS_MUX_LOCK_EN
            lk  = ($urandom_range(0, 2) == 0);
`else
            lk  = 1'b0;
`endif
            drive(rs, r, rdy, d, lk);
            acc = !rs && (r != 0) && (!m_valid || rdy);
            eg  = acc ? ref_grant(r, m_ptr) : 4'b0000;
            chk("rnd grant", 64'(grant), 64'(eg));
            chk("rnd valid", 64'(out_valid), 64'(m_valid));
            chk("rnd q_out", 64'(q_out), 64'(m_q));
            chk("rnd q_sel", 64'(q_sel), 64'(m_sel));
            if (rs) begin
                m_valid = 0; m_q = '0; m_sel = 0; m_ptr = 0;
            end else if (acc) begin
                g = $clog2(int'(eg));
                m_valid = 1;
                m_q     = d[g*16 +: 16];
                m_sel   = g;
                m_ptr   = lk ? g : (g + 1) % 4;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end

`ifdef RR_BUS_MUX_LOCK_EN
        // burst lock: source 1 keeps priority while lock is held
        drive(1, 4'b0000, 1, D0, 1'b0);
        drive(0, 4'b0011, 1, D0, 1'b0);
        chk("lock first grant", 64'(grant), 64'(4'b0001));
        drive(0, 4'b0011, 1, D0, 1'b1);
        chk("lock grant src1", 64'(grant), 64'(4'b0010));
        drive(0, 4'b0011, 1, D0, 1'b0);
        chk("lock regrant src1", 64'(grant), 64'(4'b0010));
        drive(0, 4'b0011, 1, D0, 1'b0);
        chk("unlock grant src0", 64'(grant), 64'(4'b0001));
        chk("unlock q_sel", 64'(q_sel), 64'(2'd1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_bus_mux.md
Name: rr_bus_mux

Overview:
- Parametrised, registered N-to-1 datapath bus multiplexer for the LC-3 datapath.
- Successor to the fixed 4:1 16-bit select mux.
- Replaces the external select code with per-source request lines and round-robin arbitration.
- Adds a one-entry valid/ready output register so sources (PC, ALU, MDR, MARMUX, and future DMA/IO) share one bus without a combinational select path.

Parameters:
- WIDTH, 16, data width of each source and of Q_Out.
- N, 4, number of sources; legal range 2..16, need not be a power of two.
- SEL_W, $clog2(N), width of the Q_Sel source index; derived, not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- req  input  N  per-source request; bit i means data_in slice i is valid.
- data_in  input  N*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- grant  output  N  one-hot; bit i high means source i is transferred on this edge (combinational).
- out_valid  output  1  Q_Out holds a transfer.
- out_ready  input  1  consumer accepts Q_Out this cycle.
- Q_Out  output  WIDTH  registered selected data.
- Q_Sel  output  SEL_W  index of the source that produced Q_Out.

Behaviour:
- Reset (synchronous, checked at the Clk edge):
  - out_valid=0, Q_Out=0, Q_Sel=0, round-robin pointer ptr=0.
  - grant is forced to 0 while Reset is high.
  - Reset overrides any transfer in the same cycle; data in flight is dropped.
- Output register state machine, two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- accept = |req && (EMPTY || out_ready).
- grant:
  - Asserted only when accept is true.
  - Selects the first requesting index found by scanning ptr, ptr+1, ..., wrapping N-1 to 0.
  - grant is 0 whenever accept is 0.
- On the edge with accept and grant index g:
  - Q_Out <= data_in[g].
  - Q_Sel <= g.
  - out_valid <= 1.
  - ptr <= (g==N-1) ? 0 : g+1.
- On the edge with FULL && out_ready && !|req: out_valid <= 0. Q_Out and Q_Sel hold their last values.
- FULL && !out_ready: Q_Out, Q_Sel and out_valid stay stable, and grant=0.
- Latency: one cycle from grant to out_valid. Throughput: one transfer per cycle when out_ready is held high.
- ptr changes only on a granted transfer, so idle cycles do not rotate priority.
- A single requester is always granted regardless of ptr.
- Sources must hold req and data_in until they see their grant bit. The block does not latch requests.

Optional Feature:
- Macro: RR_BUS_MUX_LOCK_EN.
- With the macro defined:
  - Extra input port lock (1 bit).
  - If lock=1 on the edge of a granted transfer to source g, ptr <= g instead of g+1. Source g keeps top priority for burst transfers (e.g. multi-word MDR moves).
  - lock has no effect on edges without a grant.
- Without the macro: the lock port does not exist, and ptr always advances as described above.

Decomposition:
- Package lc3_bus_pkg:
  - LC3_WORD_W = 16.
  - Typedef lc3_word_t = logic [15:0].
  - Constant LC3_BUS_SRC_N = 4.
  - Enum lc3_bus_src_e = {SRC_PC, SRC_ALU, SRC_MDR, SRC_MARMUX}, to give Q_Sel values meaning at top level.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and binary index.
  - Purely combinational.
- rr_bus_mux owns ptr, the output register, and the optional lock logic.

Test Plan:
- Reset, then idle with req=0 for 3 cycles -> out_valid=0, Q_Out=0, Q_Sel=0, grant=0 every cycle.
- N=4, WIDTH=16, out_ready=1, req=4'b1111 held, data_in = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA} -> grants 0,1,2,3,0. Q_Out follows one cycle later: AAAA, BBBB, CCCC, DDDD, AAAA. out_valid stays 1 throughout.
- Backpressure: FULL with Q_Out=16'h1234, out_ready=0 for 4 cycles, req=4'b0100 -> grant=0 and Q_Out stable. Raise out_ready -> grant=4'b0100 in that cycle, and the next Q_Out=data_in[2].
- Wrap and non-power-of-two: N=3, ptr=2 after granting source 1, req=3'b011 -> grant source 0 (wrap), then ptr=1.
- Reset mid-operation: FULL with Q_Out=16'hBEEF, assert Reset for one cycle with req=4'b0001 -> next cycle out_valid=0, Q_Out=0, ptr=0, and no grant during the Reset cycle.
- With RR_BUS_MUX_LOCK_EN: req=4'b0011, lock=1 on the grant to source 1 -> source 1 is granted again next cycle. Drop lock -> the following grant goes to source 0.
